nts_ip_tx_header: RTL and testbench

Transmit-side Ethernet/IPv4/UDP header generator for the NTS engine. It takes per-packet addressing and a UDP payload length, computes the IPv4 header checksum, and streams the 42-byte header as six 64-bit big-endian words. The stream goes to the TX framer, which appends the NTP/NTS payload. The 64-bit word layout and byte-mask format are identical to those used by the receive-side IP parser.

---
 rtl/nts_ip_pkg.sv | 28 ++
 rtl/nts_ip_csum16.sv | 36 +++
 rtl/nts_ip_tx_header.sv | 191 +++++++++++++++++++
 tb/tb_nts_ip_tx_header.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nts_ip_pkg.sv
`default_nettype none
// ============================================================================
// Package : nts_ip_pkg
// Shared Ethernet/IPv4/UDP constants and the TX header FSM state type.
// Rev     : 1.0  initial release
// ============================================================================
package nts_ip_pkg;

  localparam logic [15:0] E_TYPE_IPV4     = 16'h0800;
  localparam logic [3:0]  IP_V4           = 4'h4;
  localparam logic [3:0]  IHL_MIN         = 4'h5;
  localparam logic [7:0]  IP_PROTO_UDP    = 8'h11;
  localparam int          HDR_WORDS       = 6;
  localparam logic [15:0] MAX_UDP_PAYLOAD = 16'd65507;

  localparam logic [15:0] IP_FLAGS_DF     = 16'h4000;
  localparam logic [15:0] UDP_HDR_BYTES   = 16'd8;
  localparam logic [15:0] IP_UDP_HDR_BYTES = 16'd28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CSUM = 2'd1,
    FOLD = 2'd2,
    EMIT = 2'd3
  } tx_hdr_state_t;

endpackage
`default_nettype wire

// File: rtl/nts_ip_csum16.sv
`default_nettype none
// ============================================================================
// Module : nts_ip_csum16
// Sequential 16-bit ones-complement accumulator with folded, inverted result.
// Rev    : 1.0  initial release
// ============================================================================
module nts_ip_csum16 (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic        i_clear,
  input  logic        i_add,
  input  logic [15:0] i_term,
  output logic [15:0] o_csum
);

  logic [19:0] r_acc;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= r_acc + {4'd0, i_term};
    end
  end

  // Second fold cannot carry out: the first fold is at most 17'h1000E.
  assign w_fold1 = {1'b0, r_acc[15:0]} + {13'd0, r_acc[19:16]};
  assign w_fold2 = w_fold1[15:0] + {15'd0, w_fold1[16]};
  assign o_csum  = ~w_fold2;

endmodule
`default_nettype wire

// File: rtl/nts_ip_tx_header.sv
`default_nettype none
// ============================================================================
// Module : nts_ip_tx_header
// Builds the 42-byte Ethernet/IPv4/UDP header as six 64-bit big-endian words.
// Rev    : 1.0  initial release
// ============================================================================
module nts_ip_tx_header
  import nts_ip_pkg::*;
#(
  parameter logic [7:0]  TTL         = 8'd64,
  parameter logic [15:0] IDENT_RESET = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic        i_clear,
  input  logic        i_start,
  input  logic [15:0] i_payload_length,
  input  logic [47:0] i_dst_mac,
  input  logic [47:0] i_src_mac,
  input  logic [31:0] i_src_ip,
  input  logic [31:0] i_dst_ip,
  input  logic [15:0] i_src_port,
  input  logic [15:0] i_dst_port,
  input  logic        i_ready,
  output logic        o_busy,
  output logic        o_error,
  output logic        o_valid,
  output logic [63:0] o_data,
  output logic        o_last,
  output logic [7:0]  o_last_word_data_valid
);

  localparam logic [15:0] c_ver_ihl_tos = {IP_V4, IHL_MIN, 8'h00};
  localparam logic [3:0]  c_last_term   = 4'd8;
  localparam logic [2:0]  c_last_word   = 3'(HDR_WORDS - 1);

  tx_hdr_state_t r_state, w_state_next;

  logic        w_accept, w_reject, w_add, w_xfer, w_done;
  logic        w_valid;
  logic [15:0] w_term, w_csum;
  logic [63:0] w_word;

  logic        r_error;
  logic [3:0]  r_cnt;
  logic [2:0]  r_word;
  logic [15:0] r_ident, r_pkt_ident, r_total_len, r_udp_len, r_csum;
  logic [47:0] r_dst_mac, r_src_mac;
  logic [31:0] r_src_ip, r_dst_ip;
  logic [15:0] r_src_port, r_dst_port;

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_add        = 1'b0;
    w_xfer       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (i_payload_length > MAX_UDP_PAYLOAD) begin
            w_reject = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_state_next = CSUM;
          end
        end
      end
      CSUM: begin
        w_add = 1'b1;
        if (r_cnt == c_last_term) w_state_next = FOLD;
      end
      FOLD: w_state_next = EMIT;
      EMIT: begin
        if (i_ready) begin
          w_xfer = 1'b1;
          if (r_word == c_last_word) begin
            w_done       = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
    // Abort wins over everything, including the final word transfer.
    if (i_clear) begin
      w_state_next = IDLE;
      w_accept     = 1'b0;
      w_reject     = 1'b0;
      w_add        = 1'b0;
      w_xfer       = 1'b0;
      w_done       = 1'b0;
    end
  end

  always_comb begin
    w_term = '0;
    case (r_cnt)
      4'd0:    w_term = c_ver_ihl_tos;
      4'd1:    w_term = r_total_len;
      4'd2:    w_term = r_pkt_ident;
      4'd3:    w_term = IP_FLAGS_DF;
      4'd4:    w_term = {TTL, IP_PROTO_UDP};
      4'd5:    w_term = r_src_ip[31:16];
      4'd6:    w_term = r_src_ip[15:0];
      4'd7:    w_term = r_dst_ip[31:16];
      4'd8:    w_term = r_dst_ip[15:0];
      default: w_term = '0;
    endcase
  end

  nts_ip_csum16 u_csum (
    .i_clk    (i_clk),
    .i_areset (i_areset),
    .i_clear  (i_clear | w_accept),
    .i_add    (w_add),
    .i_term   (w_term),
    .o_csum   (w_csum)
  );

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_error     <= 1'b0;
      r_cnt       <= '0;
      r_word      <= '0;
      r_ident     <= IDENT_RESET;
      r_pkt_ident <= '0;
      r_total_len <= '0;
      r_udp_len   <= '0;
      r_csum      <= '0;
      r_dst_mac   <= '0;
      r_src_mac   <= '0;
      r_src_ip    <= '0;
      r_dst_ip    <= '0;
      r_src_port  <= '0;
      r_dst_port  <= '0;
    end else begin
      r_error <= w_reject;
      if (w_accept) begin
        r_cnt       <= '0;
        r_word      <= '0;
        r_pkt_ident <= r_ident;
        r_total_len <= i_payload_length + IP_UDP_HDR_BYTES;
        r_udp_len   <= i_payload_length + UDP_HDR_BYTES;
        r_dst_mac   <= i_dst_mac;
        r_src_mac   <= i_src_mac;
        r_src_ip    <= i_src_ip;
        r_dst_ip    <= i_dst_ip;
        r_src_port  <= i_src_port;
        r_dst_port  <= i_dst_port;
      end
      if (w_add) r_cnt <= r_cnt + 4'd1;
      if (r_state == FOLD && !i_clear) r_csum <= w_csum;
      if (w_xfer) r_word <= w_done ? 3'd0 : r_word + 3'd1;
      if (w_done) r_ident <= r_ident + 16'd1;
      if (i_clear) begin
        r_cnt  <= '0;
        r_word <= '0;
      end
    end
  end

  always_comb begin
    w_word = '0;
    case (r_word)
      3'd0:    w_word = {r_dst_mac, r_src_mac[47:32]};
      3'd1:    w_word = {r_src_mac[31:0], E_TYPE_IPV4, c_ver_ihl_tos};
      3'd2:    w_word = {r_total_len, r_pkt_ident, IP_FLAGS_DF, TTL, IP_PROTO_UDP};
      3'd3:    w_word = {r_csum, r_src_ip, r_dst_ip[31:16]};
      3'd4:    w_word = {r_dst_ip[15:0], r_src_port, r_dst_port, r_udp_len};
      default: w_word = '0;
    endcase
  end

  // Outputs derive from registered state so an async reset clears them at once.
  assign w_valid                = (r_state == EMIT);
  assign o_valid                = w_valid;
  assign o_busy                 = (r_state != IDLE);
  assign o_error                = r_error;
  assign o_last                 = w_valid && (r_word == c_last_word);
  assign o_data                 = w_valid ? w_word : 64'd0;
  assign o_last_word_data_valid = !w_valid ? 8'h00 : (o_last ? 8'hC0 : 8'hFF);

endmodule
`default_nettype wire

// File: tb/tb_nts_ip_tx_header.sv
`default_nettype none
// ============================================================================
// Module : tb_nts_ip_tx_header
// Directed self-checking bench for the TX Ethernet/IPv4/UDP header generator.
// Rev    : 1.0  initial release
// ============================================================================
module tb_nts_ip_tx_header;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset, clear, start, ready;
  logic [15:0] payload_length, src_port, dst_port;
  logic [47:0] dst_mac, src_mac;
  logic [31:0] src_ip, dst_ip;

  logic        busy, error, valid, last;
  logic [63:0] data;
  logic [7:0]  mask;
  logic        busy_w, error_w, valid_w, last_w;
  logic [63:0] data_w;
  logic [7:0]  mask_w;

  nts_ip_tx_header dut (
    .i_clk(clk), .i_areset(areset), .i_clear(clear), .i_start(start),
    .i_payload_length(payload_length), .i_dst_mac(dst_mac), .i_src_mac(src_mac),
    .i_src_ip(src_ip), .i_dst_ip(dst_ip), .i_src_port(src_port), .i_dst_port(dst_port),
    .i_ready(ready), .o_busy(busy), .o_error(error), .o_valid(valid), .o_data(data),
    .o_last(last), .o_last_word_data_valid(mask)
  );

  // Second instance starts its ident at FFFF so the wrap is reachable quickly.
  nts_ip_tx_header #(.IDENT_RESET(16'hFFFF)) dut_w (
    .i_clk(clk), .i_areset(areset), .i_clear(clear), .i_start(start),
    .i_payload_length(payload_length), .i_dst_mac(dst_mac), .i_src_mac(src_mac),
    .i_src_ip(src_ip), .i_dst_ip(dst_ip), .i_src_port(src_port), .i_dst_port(dst_port),
    .i_ready(ready), .o_busy(busy_w), .o_error(error_w), .o_valid(valid_w), .o_data(data_w),
    .o_last(last_w), .o_last_word_data_valid(mask_w)
  );

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [63:0] got [6];
  logic [8:0]  got_lm [6];
  logic [63:0] got_w2;
  int          first_valid, nxfer;
  logic        stall_ok, seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_csum(input logic [15:0] tl, input logic [15:0] id);
    logic [31:0] s;
    s = 32'h4500 + tl + id + 32'h4000 + 32'h4011
      + src_ip[31:16] + src_ip[15:0] + dst_ip[31:16] + dst_ip[15:0];
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return ~s[15:0];
  endfunction

  function automatic logic [63:0] exp_word(input int i, input logic [15:0] pl, input logic [15:0] id);
    logic [15:0] tl, ul;
    tl = pl + 16'd28;
    ul = pl + 16'd8;
    case (i)
      0:       return {dst_mac, src_mac[47:32]};
      1:       return {src_mac[31:0], 16'h0800, 16'h4500};
      2:       return {tl, id, 16'h4000, 8'd64, 8'h11};
      3:       return {ref_csum(tl, id), src_ip, dst_ip[31:16]};
      4:       return {dst_ip[15:0], src_port, dst_port, ul};
      default: return 64'd0;
    endcase
  endfunction

  // Called on a falling edge; returns on the falling edge after the last transfer.
  task automatic run_pkt(input logic [15:0] pl, input int stall_word, input int abort_word);
    int stalls = 0;
    logic [63:0] held = '0;
    payload_length = pl;
    start = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start       = 1'b0;
    nxfer       = 0;
    first_valid = -1;
    stall_ok    = 1'b1;
    for (int e = 0; e < 40 && nxfer < 6; e++) begin
      ready = !(nxfer == stall_word && stalls < 3);
      if (valid && nxfer == abort_word) begin
        clear = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("abort_w%0d_ctrl", abort_word), {busy, valid, error, last, mask}, 0);
        check($sformatf("abort_w%0d_data", abort_word), data, 0);
        @(negedge clk);
        clear = 1'b0;
        ready = 1'b1;
        return;
      end
      #1;
      if (valid && first_valid < 0) first_valid = e;
      if (valid && !ready) begin
        if (stalls == 0) held = data;
        else if (data !== held) stall_ok = 1'b0;
        stalls++;
      end
      if (valid && ready) begin
        if (stalls > 0 && nxfer == stall_word && data !== held) stall_ok = 1'b0;
        got[nxfer]    = data;
        got_lm[nxfer] = {last, mask};
        if (nxfer == 2) got_w2 = data_w;
        nxfer++;
      end
      @(negedge clk);
    end
    ready = 1'b1;
  endtask

  task automatic verify_pkt(input string tag, input logic [15:0] pl, input logic [15:0] id);
    check({tag, "_nxfer"}, 64'(nxfer), 64'd6);
    check({tag, "_first_valid"}, 64'(first_valid), 64'd10);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_w%0d", tag, i), got[i], exp_word(i, pl, id));
      check($sformatf("%s_lastmask%0d", tag, i), 64'(got_lm[i]),
            (i == 5) ? 64'h1C0 : 64'h0FF);
    end
    check({tag, "_idle_after"}, {busy, valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; clear = 1'b0; start = 1'b0; ready = 1'b1; payload_length = '0;
    dst_mac = 48'h0011_2233_4455; src_mac = 48'h6677_8899_AABB;
    src_ip = 32'hC0A8_0001; dst_ip = 32'hC0A8_00C7;
    src_port = 16'd123; dst_port = 16'd4460;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, error, valid, last, mask}, 0);
    check("reset_data", data, 0);
    areset = 1'b0;
    @(negedge clk);

    // Reference vector, first packet after reset
    run_pkt(16'd87, -1, -1);
    verify_pkt("ref", 16'd87, 16'h0000);
    check("ref_w2_vector", got[2], 64'h0073_0000_4000_4011);
    check("ref_csum_vector", 64'(got[3][63:48]), 64'hB861);
    check("ref_udp_len", 64'(got[4][15:0]), 64'h005F);
    check("wrap_ident_ffff", 64'(got_w2[47:32]), 64'hFFFF);

    // Back-to-back: next start is sampled on the edge right after w5
    src_ip = 32'h0A00_0001; dst_ip = 32'h0A00_00FE;
    src_port = 16'd4460; dst_port = 16'd123;
    dst_mac = 48'hDEAD_BEEF_0001; src_mac = 48'h0200_0000_0042;
    run_pkt(16'd200, -1, -1);
    verify_pkt("b2b", 16'd200, 16'h0001);
    check("wrap_ident_0000", 64'(got_w2[47:32]), 64'h0000);

    // Backpressure on w2 for three cycles
    run_pkt(16'd48, 2, -1);
    verify_pkt("stall", 16'd48, 16'h0002);
    check("stall_hold", 64'(stall_ok), 64'd1);

    // Largest legal payload
    run_pkt(16'd65507, -1, -1);
    verify_pkt("maxlen", 16'd65507, 16'h0003);
    check("maxlen_total", 64'(got[2][63:48]), 64'hFFFF);

    // Oversize payload is rejected
    payload_length = 16'd65508;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("err_pulse", {error, busy}, 2'b10);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("err_one_cycle", 64'(error), 64'd0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (valid || busy) seen = 1'b1;
    end
    check("err_no_valid", 64'(seen), 64'd0);
    run_pkt(16'd100, -1, -1);
    verify_pkt("after_err", 16'd100, 16'h0004);

    // Abort during CSUM
    payload_length = 16'd60;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("csum_busy", 64'(busy), 64'd1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    check("clr_csum_ctrl", {busy, valid, error, last, mask}, 0);
    check("clr_csum_data", data, 0);
    @(negedge clk);
    clear = 1'b0;
    run_pkt(16'd77, -1, -1);
    verify_pkt("after_clr_csum", 16'd77, 16'h0005);

    // Abort during EMIT at w3, then abort racing the w5 transfer
    run_pkt(16'd300, -1, 3);
    run_pkt(16'd40, -1, -1);
    verify_pkt("after_clr_w3", 16'd40, 16'h0006);
    run_pkt(16'd10, -1, 5);
    run_pkt(16'd41, -1, -1);
    verify_pkt("after_clr_w5", 16'd41, 16'h0007);

    // Asynchronous reset mid-EMIT
    payload_length = 16'd500;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_reset_valid", 64'(valid), 64'd1);
    #2 areset = 1'b1;
    #1;
    check("areset_ctrl", {busy, valid, error, last, mask}, 0);
    check("areset_data", data, 0);
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    run_pkt(16'd87, -1, -1);
    verify_pkt("after_areset", 16'd87, 16'h0000);
    check("areset_wrap_ident", 64'(got_w2[47:32]), 64'hFFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
